// File: rtl/uart_baud_gen_frac.sv
// Fractional baud generator: divides clk by a programmable int.frac divisor and
// emits oversample, mid-bit and bit-boundary strobes with shadowed divisor updates.
module uart_baud_gen_frac #(
  parameter int     CLK_HZ   = 20000000,
  parameter int     BAUD_DEF = 9600,
  parameter int     OSR      = 16,
  parameter int     INT_W    = 16,
  parameter int     FRAC_W   = 4,
  parameter longint DIV_DEF  = (longint'(CLK_HZ) * (longint'(1) << FRAC_W)
                                + longint'(OSR * BAUD_DEF / 2)) / longint'(OSR * BAUD_DEF)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    en,
  input  logic                    resync,
  input  logic                    div_wr,
  input  logic [INT_W-1:0]        div_int,
  input  logic [FRAC_W-1:0]       div_frac,
  output logic                    tick_os,
  output logic                    tick_mid,
  output logic                    tick_bit,
  output logic [$clog2(OSR)-1:0]  os_idx,
  output logic                    div_pend,
  output logic [INT_W-1:0]        cur_int,
  output logic [FRAC_W-1:0]       cur_frac
);

  localparam int                OS_W     = $clog2(OSR);
  localparam logic [INT_W-1:0]  DEF_INT  = INT_W'(DIV_DEF >>> FRAC_W);
  localparam logic [FRAC_W-1:0] DEF_FRAC = FRAC_W'(DIV_DEF);
  localparam logic [INT_W:0]    CNT_ONE  = (INT_W+1)'(1);
  localparam logic [OS_W-1:0]   OS_LAST  = OS_W'(OSR - 1);
  localparam logic [OS_W-1:0]   OS_MID   = OS_W'(OSR / 2 - 1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t              state;
  logic [INT_W:0]      cnt;
  logic [INT_W:0]      p_len;
  logic [FRAC_W-1:0]   acc;
  logic [INT_W-1:0]    shd_int;
  logic [FRAC_W-1:0]   shd_frac;

  logic [INT_W-1:0]    wr_int;
  logic [INT_W-1:0]    nxt_int;
  logic [FRAC_W-1:0]   nxt_frac;
  logic [FRAC_W:0]     sum;
  logic [INT_W:0]      nxt_p;
  logic                wrap;
  logic                last_os;
  logic                load_direct;
  logic                apply_shd;

  function automatic logic [INT_W-1:0] clamp_int(input logic [INT_W-1:0] v);
    return (v < INT_W'(2)) ? INT_W'(2) : v;
  endfunction

  always_comb begin
    wr_int      = clamp_int(div_int);
    wrap        = (state == RUN) && (cnt == p_len - CNT_ONE);
    last_os     = (os_idx == OS_LAST);
    load_direct = div_wr && ((state == IDLE) || !en);
    // A pending divisor lands at a bit boundary, on resync-over-wrap, or on IDLE entry
    apply_shd   = (state == RUN) && div_pend && (!en || (wrap && (resync || last_os)));
    nxt_int     = cur_int;
    nxt_frac    = cur_frac;
    if (load_direct) begin
      nxt_int  = wr_int;
      nxt_frac = div_frac;
    end else if (apply_shd) begin
      nxt_int  = shd_int;
      nxt_frac = shd_frac;
    end
    // The next interval is sized from the divisor that becomes active on this edge
    sum   = {1'b0, resync ? FRAC_W'(0) : acc} + {1'b0, nxt_frac};
    nxt_p = {1'b0, nxt_int} + {{INT_W{1'b0}}, sum[FRAC_W]};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      cnt      <= '0;
      acc      <= '0;
      os_idx   <= '0;
      tick_os  <= 1'b0;
      tick_mid <= 1'b0;
      tick_bit <= 1'b0;
      div_pend <= 1'b0;
      cur_int  <= DEF_INT;
      cur_frac <= DEF_FRAC;
    end else begin
      tick_os  <= 1'b0;
      tick_mid <= 1'b0;
      tick_bit <= 1'b0;
      cur_int  <= nxt_int;
      cur_frac <= nxt_frac;
      case (state)
        IDLE: begin
          cnt      <= '0;
          os_idx   <= '0;
          div_pend <= 1'b0;
          acc      <= '0;
          if (en) begin
            state <= RUN;
            acc   <= sum[FRAC_W-1:0];
          end
        end
        RUN: begin
          if (!en) begin
            state    <= IDLE;
            cnt      <= '0;
            acc      <= '0;
            os_idx   <= '0;
            div_pend <= 1'b0;
          end else begin
            if (resync) begin
              cnt    <= '0;
              os_idx <= '0;
              acc    <= sum[FRAC_W-1:0];
            end else if (wrap) begin
              cnt      <= '0;
              acc      <= sum[FRAC_W-1:0];
              os_idx   <= last_os ? '0 : os_idx + OS_W'(1);
              tick_os  <= 1'b1;
              tick_mid <= (os_idx == OS_MID);
              tick_bit <= last_os;
            end else begin
              cnt <= cnt + CNT_ONE;
            end
            // A write on the boundary edge overrides the pend-clear
            if (div_wr)
              div_pend <= 1'b1;
            else if (apply_shd)
              div_pend <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Interval length and shadow divisor carry no reset; both are loaded before use
  always_ff @(posedge clk) begin
    if (((state == IDLE) && en) || ((state == RUN) && en && (resync || wrap)))
      p_len <= nxt_p;
    if ((state == RUN) && en && div_wr) begin
      shd_int  <= wr_int;
      shd_frac <= div_frac;
    end
  end

endmodule
